// File: rtl/player_lives_hit.sv
// Life counter for bomberman: detects explosion/enemy contact with the 16x16
// hitbox, runs post-hit invincibility with a sprite blink, and owns gameover.
module player_lives_hit #(
    parameter int LIVES_INIT        = 3,
    parameter int HURT_COUNTER_MAX  = 100000000,
    parameter int BLINK_COUNTER_MAX = 10000000,
    parameter int X_WALL_L          = 48,
    parameter int Y_WALL_U          = 32,
    parameter int BM_HB_OFFSET_9    = 8,
    parameter int BM_HB_SIZE        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x_a,
    input  logic [9:0] y_a,
    input  logic [9:0] x_b,
    input  logic [9:0] y_b,
    input  logic       exp_on,
    input  logic       enemy_hit,
    input  logic       restart,
    output logic [1:0] lives,
    output logic       gameover,
    output logic       bm_visible,
    output logic       hit_pulse
);

    typedef enum logic [1:0] {
        ALIVE    = 2'd0,
        HURT     = 2'd1,
        GAMEOVER = 2'd2
    } state_e;

    localparam logic [1:0]  LIVES_INIT_V = 2'(LIVES_INIT);
    localparam logic [26:0] HURT_LAST    = 27'(HURT_COUNTER_MAX - 1);
    localparam logic [23:0] BLINK_LAST   = 24'(BLINK_COUNTER_MAX - 1);

    state_e      state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic        gameover_q, gameover_d;
    logic        bm_visible_q, bm_visible_d;
    logic        hit_pulse_q, hit_pulse_d;
    logic [26:0] hurt_cnt_q, hurt_cnt_d;
    logic [23:0] blink_cnt_q, blink_cnt_d;
    logic        hit_req_q, hit_req_d;
    logic        restart_q, restart_d;

    // Screen-frame coordinates and hitbox edges, widened so no sum can wrap.
    logic [10:0] x_scr, y_scr;
    logic [10:0] hb_left, hb_right, hb_top, hb_bottom;
    logic        overlap;
    logic        restart_rise;

    always_comb begin
        x_scr     = {1'b0, x_a} + 11'(X_WALL_L);
        y_scr     = {1'b0, y_a} + 11'(Y_WALL_U);
        hb_left   = {1'b0, x_b};
        hb_right  = {1'b0, x_b} + 11'(BM_HB_SIZE);
        hb_top    = {1'b0, y_b} + 11'(BM_HB_OFFSET_9);
        hb_bottom = {1'b0, y_b} + 11'(BM_HB_OFFSET_9 + BM_HB_SIZE);
        overlap   = exp_on
                  & (x_scr >= hb_left) & (x_scr < hb_right)
                  & (y_scr >= hb_top)  & (y_scr < hb_bottom);
    end

    assign hit_req_d    = overlap | enemy_hit;
    assign restart_d    = restart;
    assign restart_rise = restart & ~restart_q;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        gameover_d   = gameover_q;
        bm_visible_d = bm_visible_q;
        hit_pulse_d  = 1'b0;
        hurt_cnt_d   = '0;
        blink_cnt_d  = '0;

        case (state_q)
            ALIVE: begin
                if (hit_req_q) begin
                    hit_pulse_d  = 1'b1;
                    bm_visible_d = 1'b0;
                    if (lives_q == 2'd1) begin
                        lives_d    = 2'd0;
                        gameover_d = 1'b1;
                        state_d    = GAMEOVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = HURT;
                    end
                end
            end

            HURT: begin
                // Invincible: hit requests are not looked at in this state.
                if (hurt_cnt_q == HURT_LAST) begin
                    bm_visible_d = 1'b1;
                    state_d      = ALIVE;
                end else begin
                    hurt_cnt_d = hurt_cnt_q + 27'd1;
                    if (blink_cnt_q == BLINK_LAST) begin
                        bm_visible_d = ~bm_visible_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 24'd1;
                    end
                end
            end

            GAMEOVER: begin
                gameover_d   = 1'b1;
                bm_visible_d = 1'b0;
                lives_d      = 2'd0;
                if (restart_rise) begin
                    lives_d      = LIVES_INIT_V;
                    gameover_d   = 1'b0;
                    bm_visible_d = 1'b1;
                    state_d      = ALIVE;
                end
            end

            default: begin
                state_d = ALIVE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ALIVE;
            lives_q      <= LIVES_INIT_V;
            gameover_q   <= 1'b0;
            bm_visible_q <= 1'b1;
            hit_pulse_q  <= 1'b0;
            hurt_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            hit_req_q    <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            gameover_q   <= gameover_d;
            bm_visible_q <= bm_visible_d;
            hit_pulse_q  <= hit_pulse_d;
            hurt_cnt_q   <= hurt_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            hit_req_q    <= hit_req_d;
            restart_q    <= restart_d;
        end
    end

    assign lives      = lives_q;
    assign gameover   = gameover_q;
    assign bm_visible = bm_visible_q;
    assign hit_pulse  = hit_pulse_q;

endmodule

// File: tb/tb_player_lives_hit.sv
// Directed bench for player_lives_hit with short hurt/blink periods.
module tb_player_lives_hit;

    localparam int HURT  = 20;
    localparam int BLINK = 4;
    localparam int LIVES = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic       exp_on, enemy_hit, restart;
    logic [1:0] lives;
    logic       gameover, bm_visible, hit_pulse;

    int checks = 0;
    int errors = 0;

    player_lives_hit #(
        .LIVES_INIT       (LIVES),
        .HURT_COUNTER_MAX (HURT),
        .BLINK_COUNTER_MAX(BLINK),
        .X_WALL_L         (48),
        .Y_WALL_U         (32),
        .BM_HB_OFFSET_9   (8),
        .BM_HB_SIZE       (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x_a       (x_a),
        .y_a       (y_a),
        .x_b       (x_b),
        .y_b       (y_b),
        .exp_on    (exp_on),
        .enemy_hit (enemy_hit),
        .restart   (restart),
        .lives     (lives),
        .gameover  (gameover),
        .bm_visible(bm_visible),
        .hit_pulse (hit_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    // One enemy_hit pulse; returns just after the edge where the FSM acts.
    task automatic enemy_pulse();
        enemy_hit = 1'b1;
        step(1);
        enemy_hit = 1'b0;
        step(1);
    endtask

    initial begin
        int pulses;
        reset     = 1'b1;
        x_a       = 10'd0;
        y_a       = 10'd0;
        x_b       = 10'd100;
        y_b       = 10'd60;
        exp_on    = 1'b0;
        enemy_hit = 1'b0;
        restart   = 1'b0;

        // Reset state
        step(2);
        reset = 1'b0;
        step(3);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_gameover", 32'(gameover), 32'd0);
        check("rst_visible", 32'(bm_visible), 32'd1);
        check("rst_pulse", 32'(hit_pulse), 32'd0);

        // Explosion pixel inside hitbox (screen 108,72), full hurt/blink sequence
        x_a = 10'd60; y_a = 10'd40; exp_on = 1'b1;
        step(1);
        exp_on = 1'b0;
        check("hit_pulse_early", 32'(hit_pulse), 32'd0);
        check("lives_early", 32'(lives), 32'd3);
        step(1);
        check("hit_pulse", 32'(hit_pulse), 32'd1);
        check("hit_lives", 32'(lives), 32'd2);
        check("hit_visible", 32'(bm_visible), 32'd0);
        for (int k = 1; k < HURT; k++) begin
            step(1);
            check("hurt_pulse_low", 32'(hit_pulse), 32'd0);
            check("blink", 32'(bm_visible), 32'((k / BLINK) % 2));
        end
        step(1);
        check("hurt_end_visible", 32'(bm_visible), 32'd1);
        check("hurt_end_lives", 32'(lives), 32'd2);

        // Hitbox right edge: screen x 116 misses, 115 hits
        do_reset();
        x_a = 10'd68; y_a = 10'd40; exp_on = 1'b1;
        step(1);
        exp_on = 1'b0;
        step(1);
        check("edge_out_pulse", 32'(hit_pulse), 32'd0);
        check("edge_out_lives", 32'(lives), 32'd3);
        x_a = 10'd67; exp_on = 1'b1;
        step(1);
        exp_on = 1'b0;
        step(1);
        check("edge_in_pulse", 32'(hit_pulse), 32'd1);
        check("edge_in_lives", 32'(lives), 32'd2);

        // Enemy hits during HURT cycles 5 and 15 cost nothing
        pulses = 0;
        for (int k = 1; k <= 25; k++) begin
            enemy_hit = (k == 5 || k == 15);
            step(1);
            enemy_hit = 1'b0;
            if (hit_pulse) pulses++;
        end
        check("invincible_pulses", 32'(pulses), 32'd0);
        check("invincible_lives", 32'(lives), 32'd2);
        check("invincible_visible", 32'(bm_visible), 32'd1);

        // Overlap and enemy_hit together count once
        do_reset();
        x_a = 10'd60; y_a = 10'd40; exp_on = 1'b1; enemy_hit = 1'b1;
        step(1);
        exp_on = 1'b0; enemy_hit = 1'b0;
        step(1);
        check("dual_pulse", 32'(hit_pulse), 32'd1);
        check("dual_lives", 32'(lives), 32'd2);
        step(1);
        check("dual_pulse_drop", 32'(hit_pulse), 32'd0);

        // Restart in ALIVE has no effect
        do_reset();
        restart = 1'b1;
        step(2);
        restart = 1'b0;
        step(1);
        check("restart_alive_lives", 32'(lives), 32'd3);
        check("restart_alive_gameover", 32'(gameover), 32'd0);

        // Three spaced hits to GAMEOVER, restart already high on entry
        enemy_pulse();
        check("three_1", 32'(lives), 32'd2);
        step(HURT);
        enemy_pulse();
        check("three_2", 32'(lives), 32'd1);
        step(HURT);
        check("three_2_alive", 32'(bm_visible), 32'd1);
        restart = 1'b1;
        step(2);
        enemy_hit = 1'b1;
        step(1);
        enemy_hit = 1'b0;
        check("go_not_yet", 32'(gameover), 32'd0);
        step(1);
        check("go_flag", 32'(gameover), 32'd1);
        check("go_lives", 32'(lives), 32'd0);
        check("go_visible", 32'(bm_visible), 32'd0);
        check("go_pulse", 32'(hit_pulse), 32'd1);
        step(4);
        check("go_held_restart", 32'(gameover), 32'd1);
        enemy_pulse();
        check("go_ignore_hit_pulse", 32'(hit_pulse), 32'd0);
        check("go_ignore_hit_lives", 32'(lives), 32'd0);
        restart = 1'b0;
        step(2);
        check("go_restart_low", 32'(gameover), 32'd1);
        restart = 1'b1;
        step(1);
        check("restart_gameover", 32'(gameover), 32'd0);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_visible", 32'(bm_visible), 32'd1);
        restart = 1'b0;
        step(2);

        // Asynchronous reset at HURT cycle 10
        enemy_pulse();
        step(10);
        check("mid_hurt_visible", 32'(bm_visible), 32'd0);
        check("mid_hurt_lives", 32'(lives), 32'd2);
        reset = 1'b1;
        #1;
        check("async_lives", 32'(lives), 32'd3);
        check("async_visible", 32'(bm_visible), 32'd1);
        check("async_gameover", 32'(gameover), 32'd0);
        step(1);
        reset = 1'b0;
        step(2);
        enemy_pulse();
        check("post_reset_hit", 32'(lives), 32'd2);
        check("post_reset_pulse", 32'(hit_pulse), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
